// File: rtl/rgb_pwm_decoder8_pkg.sv
// Shared types and constants for the RGB PWM duty decoder.
package rgb_pwm_decoder8_pkg;

  localparam int unsigned FRAME_LEN      = 256;
  localparam int unsigned DefaultTimeout = 320;
  localparam int unsigned NumChan        = 3;
  localparam int unsigned CntW           = 9;

  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } cap_state_e;

  // On-time counts of a full frame or more report full brightness.
  function automatic logic [7:0] clamp_duty(logic [CntW-1:0] cnt);
    if (cnt >= CntW'(FRAME_LEN)) begin
      return 8'hFF;
    end
    return cnt[7:0];
  endfunction

endpackage

// File: rtl/rgb_pwm_decoder8_if.sv
// Pin and result bundle between an RGB PWM source and the decoder.
interface rgb_pwm_decoder8_if;

  logic       r_i;
  logic       g_i;
  logic       b_i;
  logic       an;
  logic [7:0] rcolor_o;
  logic [7:0] gcolor_o;
  logic [7:0] bcolor_o;
  logic [2:0] valid_o;
  logic       locked_o;

  modport master (
    output r_i, g_i, b_i, an,
    input  rcolor_o, gcolor_o, bcolor_o, valid_o, locked_o
  );

  modport slave (
    input  r_i, g_i, b_i, an,
    output rcolor_o, gcolor_o, bcolor_o, valid_o, locked_o
  );

endinterface

// File: rtl/rgb_pwm_decoder8_pwm_capture_channel.sv
// One PWM channel: pin synchronizer, edge detect, on-time measurement FSM and
// steady-level timeout. Polarity is applied outside and fed back as level_i.
module pwm_capture_channel
  import rgb_pwm_decoder8_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pin_i,
  output logic       sync_o,
  input  logic       level_i,
  output logic [7:0] color_o,
  output logic       valid_o,
  output logic       seen_o
);

  localparam logic [CntW-1:0] IdleLimit = CntW'(TIMEOUT - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_prev_q;
  logic [3:0]      prime_q;
  cap_state_e      state_q, state_d;
  logic [CntW-1:0] high_q, high_d;
  logic [CntW-1:0] idle_q, idle_d;
  logic [7:0]      color_q, color_d;
  logic            valid_q, valid_d;
  logic            seen_q, seen_d;
  logic            lvl_edge, lvl_rise, lvl_fall, timeout_hit;

  assign sync_o = sync_q[1];

  // Edges are ignored until level_prev_q holds a real pin sample, so a pin
  // that is already high when reset releases cannot start a partial count.
  assign lvl_edge    = (level_q ^ level_prev_q) & prime_q[3];
  assign lvl_rise    = lvl_edge & level_q;
  assign lvl_fall    = lvl_edge & ~level_q;
  assign timeout_hit = !lvl_edge && (idle_q == IdleLimit);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      prime_q      <= '0;
      state_q      <= StWait;
      high_q       <= '0;
      idle_q       <= '0;
      color_q      <= 8'h00;
      valid_q      <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pin_i};
      level_q      <= level_i;
      level_prev_q <= level_q;
      prime_q      <= {prime_q[2:0], 1'b1};
      state_q      <= state_d;
      high_q       <= high_d;
      idle_q       <= idle_d;
      color_q      <= color_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    color_d = color_q;
    valid_d = 1'b0;

    // Saturation keeps the timeout from re-firing during a long steady level.
    if (lvl_edge) begin
      idle_d = '0;
    end else if (idle_q != CntMax) begin
      idle_d = idle_q + CntW'(1);
    end else begin
      idle_d = idle_q;
    end

    if (timeout_hit) begin
      color_d = level_q ? 8'hFF : 8'h00;
      valid_d = 1'b1;
      state_d = StWait;
    end else begin
      unique case (state_q)
        StWait: begin
          if (lvl_rise) begin
            high_d  = CntW'(1);
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (lvl_fall) begin
            state_d = StLow;
          end else if (level_q && (high_q != CntMax)) begin
            high_d = high_q + CntW'(1);
          end
        end
        StLow: begin
          if (lvl_rise) begin
            color_d = clamp_duty(high_q);
            valid_d = 1'b1;
            high_d  = CntW'(1);
            state_d = StHigh;
          end
        end
        default: state_d = StWait;
      endcase
    end

    seen_d = seen_q | valid_d;
  end

  assign color_o = color_q;
  assign valid_o = valid_q;
  assign seen_o  = seen_q;

endmodule

// File: rtl/rgb_pwm_decoder8.sv
// Recovers 8-bit duty cycles from the three pins of an RGB PWM driver.
module rgb_pwm_decoder8
  import rgb_pwm_decoder8_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input logic               clk,
  input logic               rst,
  rgb_pwm_decoder8_if.slave bus
);

  logic [NumChan-1:0] pin;
  logic [NumChan-1:0] sync;
  logic [NumChan-1:0] level;
  logic [NumChan-1:0] valid;
  logic [NumChan-1:0] seen;
  logic [7:0]         color [NumChan];
  logic               locked_q, locked_d;

  // Bit 2 = red, bit 1 = green, bit 0 = blue throughout.
  assign pin   = {bus.r_i, bus.g_i, bus.b_i};
  assign level = sync ^ {NumChan{bus.an}};

  for (genvar i = 0; i < NumChan; i++) begin : g_chan
    pwm_capture_channel #(
      .TIMEOUT(TIMEOUT)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .pin_i  (pin[i]),
      .sync_o (sync[i]),
      .level_i(level[i]),
      .color_o(color[i]),
      .valid_o(valid[i]),
      .seen_o (seen[i])
    );
  end

  always_comb begin
    locked_d = locked_q | (&seen);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end

  assign bus.rcolor_o = color[2];
  assign bus.gcolor_o = color[1];
  assign bus.bcolor_o = color[0];
  assign bus.valid_o  = valid;
  assign bus.locked_o = locked_q;

endmodule
